uart_tx_arbiter: RTL and testbench

//  Shares one serial transmitter (send-pulse / 8-bit data / txd serializer) between N_REQ byte sources.

---
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART serializer between N_REQ byte sources.
// A granted byte is latched and held until the frame and its trailing gap have elapsed.
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = 8,
    parameter int FRAME_CYCLES = 11,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_en,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*DATA_W-1:0]   i_req_data,
    output logic [N_REQ-1:0]          o_gnt,
    output logic                      o_send,
    output logic [DATA_W-1:0]         o_data,
    output logic                      o_busy,
    output logic [2:0]                o_gnt_idx,
    output logic [15:0]               o_frame_cnt
);

    localparam int T_MAX   = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int TIMER_W = $clog2(T_MAX) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_GAP
    } state_t;

    state_t               r_state, r_state_next;
    logic [TIMER_W-1:0]   r_timer, r_timer_next;
    logic [N_REQ-1:0]     r_gnt, r_gnt_next;
    logic                 r_send, r_send_next;
    logic [DATA_W-1:0]    r_data, r_data_next;
    logic                 r_busy, r_busy_next;
    logic [2:0]           r_gnt_idx, r_gnt_idx_next;
    logic [15:0]          r_frame_cnt, r_frame_cnt_next;

    logic [7:0]           w_req_pad;
    logic [DATA_W-1:0]    w_bytes [8];
    logic [3:0]           w_cand;
    logic                 w_found;
    logic [2:0]           w_winner;

    assign w_req_pad = 8'(i_req);

    // Unused slots read as zero so the winner index can address a fixed 8-entry table.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bytes
            if (gi < N_REQ) begin : g_used
                assign w_bytes[gi] = i_req_data[gi*DATA_W +: DATA_W];
            end else begin : g_pad
                assign w_bytes[gi] = '0;
            end
        end
    endgenerate

    // Scan starts one past the last winner so the previous owner has lowest priority.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = {1'b0, r_gnt_idx} + 4'(k);
            if (w_cand >= 4'(N_REQ)) begin
                w_cand = w_cand - 4'(N_REQ);
            end
            if (!w_found && w_req_pad[w_cand[2:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[2:0];
            end
        end
    end

    always_comb begin
        r_state_next     = r_state;
        r_timer_next     = r_timer;
        r_gnt_next       = '0;
        r_send_next      = 1'b0;
        r_data_next      = r_data;
        r_busy_next      = r_busy;
        r_gnt_idx_next   = r_gnt_idx;
        r_frame_cnt_next = r_frame_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_en && w_found) begin
                    r_data_next    = w_bytes[w_winner];
                    for (int i = 0; i < N_REQ; i++) begin
                        r_gnt_next[i] = (w_winner == 3'(i));
                    end
                    r_gnt_idx_next = w_winner;
                    r_send_next    = 1'b1;
                    r_busy_next    = 1'b1;
                    r_state_next   = S_SEND;
                end
            end
            S_SEND: begin
                r_timer_next     = TIMER_W'(FRAME_CYCLES - 1);
                r_frame_cnt_next = r_frame_cnt + 16'd1;
                r_state_next     = S_WAIT;
            end
            S_WAIT: begin
                if (r_timer == '0) begin
                    r_timer_next = TIMER_W'(GAP_CYCLES - 1);
                    r_state_next = S_GAP;
                end else begin
                    r_timer_next = r_timer - 1'b1;
                end
            end
            S_GAP: begin
                if (r_timer == '0) begin
                    r_busy_next  = 1'b0;
                    r_state_next = S_IDLE;
                end else begin
                    r_timer_next = r_timer - 1'b1;
                end
            end
            default: begin
                r_state_next = S_IDLE;
                r_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_gnt       <= '0;
            r_send      <= 1'b0;
            r_data      <= '0;
            r_busy      <= 1'b0;
            r_gnt_idx   <= 3'(N_REQ - 1);
            r_frame_cnt <= '0;
        end else begin
            r_state     <= r_state_next;
            r_timer     <= r_timer_next;
            r_gnt       <= r_gnt_next;
            r_send      <= r_send_next;
            r_data      <= r_data_next;
            r_busy      <= r_busy_next;
            r_gnt_idx   <= r_gnt_idx_next;
            r_frame_cnt <= r_frame_cnt_next;
        end
    end

    assign o_gnt       = r_gnt;
    assign o_send      = r_send;
    assign o_data      = r_data;
    assign o_busy      = r_busy;
    assign o_gnt_idx   = r_gnt_idx;
    assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; includes a behavioural 10-bit serializer
// (start, 8 data LSB first, stop, one bit per clock) for the end-to-end check.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        send;
    logic [7:0]  data;
    logic        busy;
    logic [2:0]  gnt_idx;
    logic [15:0] frame_cnt;

    int n_vec = 0;
    int n_err = 0;

    logic [9:0]  ser_sh;
    logic [3:0]  ser_cnt;
    logic        txd;

    uart_tx_arbiter dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (en),
        .i_req       (req),
        .i_req_data  (req_data),
        .o_gnt       (gnt),
        .o_send      (send),
        .o_data      (data),
        .o_busy      (busy),
        .o_gnt_idx   (gnt_idx),
        .o_frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ser_sh  <= '1;
            ser_cnt <= '0;
        end else if (send) begin
            ser_sh  <= {1'b1, data, 1'b0};
            ser_cnt <= 4'd10;
        end else if (ser_cnt != 0) begin
            ser_sh  <= {1'b1, ser_sh[9:1]};
            ser_cnt <= ser_cnt - 4'd1;
        end
    end
    assign txd = (ser_cnt != 0) ? ser_sh[0] : 1'b1;

    task automatic do_reset;
        req = 4'h0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        en       = 1'b1;
        req      = 4'hF;
        req_data = 32'h44332211;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (gnt !== 4'h0) begin n_err++; $display("FAIL reset_gnt got %h want 0", gnt); end
            n_vec++; if (send !== 1'b0) begin n_err++; $display("FAIL reset_send got %b want 0", send); end
            n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", data); end
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        end
        n_vec++; if (gnt_idx !== 3'd3) begin n_err++; $display("FAIL reset_gnt_idx got %0d want 3", gnt_idx); end
        n_vec++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset release: gnt=%b send=%b data=%h", gnt, send, data);
        n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL reset_first_gnt got %b want 0001", gnt); end
        n_vec++; if (send !== 1'b1) begin n_err++; $display("FAIL reset_first_send got %b want 1", send); end
        n_vec++; if (data !== 8'h11) begin n_err++; $display("FAIL reset_first_data got %h want 11", data); end
        req = 4'h0;
        repeat (13) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy got %b want 0", busy); end
    endtask

    task automatic test_single;
        do_reset();
        req_data = 32'h00A50000;
        req      = 4'b0100;
        @(negedge clk);
        $display("single: gnt=%b send=%b data=%h", gnt, send, data);
        n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt got %b want 0100", gnt); end
        n_vec++; if (send !== 1'b1) begin n_err++; $display("FAIL single_send got %b want 1", send); end
        n_vec++; if (data !== 8'hA5) begin n_err++; $display("FAIL single_data got %h want a5", data); end
        req = 4'h0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            n_vec++;
            if (send !== 1'b0 || gnt !== 4'h0 || data !== 8'hA5 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL single_hold c=%0d got send=%b gnt=%b data=%h busy=%b want 0 0000 a5 1",
                         c, send, gnt, data, busy);
            end
        end
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_end got %b want 0", busy); end
        n_vec++; if (frame_cnt !== 16'd1) begin n_err++; $display("FAIL single_frame_cnt got %0d want 1", frame_cnt); end
        n_vec++; if (gnt_idx !== 3'd2) begin n_err++; $display("FAIL single_gnt_idx got %0d want 2", gnt_idx); end
    endtask

    task automatic test_round_robin;
        int          ns;
        logic [3:0]  exp_gnt;
        logic [7:0]  exp_data;
        logic        prev_send;
        do_reset();
        req_data  = 32'h44332211;
        req       = 4'hF;
        ns        = 0;
        prev_send = 1'b0;
        for (int c = 1; c <= 57; c++) begin
            @(negedge clk);
            n_vec++;
            if ((send && gnt == 4'h0) || (send && prev_send)) begin
                n_err++;
                $display("FAIL rr_send_rule c=%0d send=%b prev=%b gnt=%b", c, send, prev_send, gnt);
            end
            prev_send = send;
            if (send) begin
                exp_gnt  = 4'b0001 << (ns % 4);
                exp_data = 8'(8'h11 * ((ns % 4) + 1));
                $display("rr grant %0d at cycle %0d: gnt=%b data=%h", ns, c, gnt, data);
                n_vec++; if (gnt !== exp_gnt) begin n_err++; $display("FAIL rr_gnt n=%0d got %b want %b", ns, gnt, exp_gnt); end
                n_vec++; if (data !== exp_data) begin n_err++; $display("FAIL rr_data n=%0d got %h want %h", ns, data, exp_data); end
                n_vec++; if (c !== 1 + 14 * ns) begin n_err++; $display("FAIL rr_spacing n=%0d got cycle %0d want %0d", ns, c, 1 + 14 * ns); end
                ns++;
            end
        end
        req = 4'h0;
        n_vec++; if (ns !== 5) begin n_err++; $display("FAIL rr_count got %0d want 5", ns); end
        repeat (13) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_enable;
        int bad;
        req = 4'hF;
        en  = 1'b1;
        @(negedge clk);
        $display("enable: first gnt=%b", gnt);
        n_vec++; if (gnt !== 4'b0010 || send !== 1'b1) begin n_err++; $display("FAIL en_first got gnt=%b send=%b want 0010 1", gnt, send); end
        en = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            n_vec++;
            if (busy !== 1'b1 || send !== 1'b0) begin
                n_err++;
                $display("FAIL en_frame c=%0d got busy=%b send=%b want 1 0", c, busy, send);
            end
        end
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL en_busy_fall got %b want 0", busy); end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (gnt !== 4'h0 || send !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL en_blocked got %0d active cycles want 0", bad); end
        en = 1'b1;
        @(negedge clk);
        $display("enable: resumed gnt=%b data=%h", gnt, data);
        n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL en_resume_gnt got %b want 0100", gnt); end
        n_vec++; if (data !== 8'h33) begin n_err++; $display("FAIL en_resume_data got %h want 33", data); end
        req = 4'h0;
        repeat (13) @(negedge clk);
    endtask

    task automatic test_mid_reset;
        req = 4'b0010;
        @(negedge clk);
        n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL mr_gnt got %b want 0010", gnt); end
        req = 4'h0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("mid reset: gnt=%b send=%b data=%h busy=%b idx=%0d cnt=%0d",
                 gnt, send, data, busy, gnt_idx, frame_cnt);
        n_vec++;
        if (gnt !== 4'h0 || send !== 1'b0 || data !== 8'h00 || busy !== 1'b0 ||
            gnt_idx !== 3'd3 || frame_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL mr_async got gnt=%b send=%b data=%h busy=%b idx=%0d cnt=%0d want 0000 0 00 0 3 0",
                     gnt, send, data, busy, gnt_idx, frame_cnt);
        end
        req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL mr_first_gnt got %b want 0001", gnt); end
        n_vec++; if (data !== 8'h11) begin n_err++; $display("FAIL mr_first_data got %h want 11", data); end
        req = 4'h0;
        repeat (13) @(negedge clk);
    endtask

    task automatic test_end_to_end;
        int          ptr [3];
        int          nrx;
        int          cyc;
        logic        rx_act;
        int          rx_n;
        logic [7:0]  rx_b;
        logic [7:0]  exp;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ptr[i] = 0;
            req_data[i*8 +: 8] = 8'((i + 1) * 16);
        end
        req_data[31:24] = 8'h00;
        req    = 4'b0111;
        nrx    = 0;
        cyc    = 0;
        rx_act = 1'b0;
        rx_n   = 0;
        rx_b   = 8'h00;
        while (cyc < 450 && !(nrx == 24 && !busy)) begin
            @(negedge clk);
            cyc++;
            if (!rx_act) begin
                if (txd == 1'b0) begin
                    rx_act = 1'b1;
                    rx_n   = 0;
                end
            end else if (rx_n < 8) begin
                rx_b[rx_n] = txd;
                rx_n++;
            end else begin
                rx_act = 1'b0;
                exp    = 8'(((nrx % 3) + 1) * 16 + nrx / 3);
                $display("e2e byte %0d: rx=%h stop=%b", nrx, rx_b, txd);
                n_vec++;
                if (txd !== 1'b1 || rx_b !== exp) begin
                    n_err++;
                    $display("FAIL e2e_byte n=%0d got %h stop=%b want %h stop=1", nrx, rx_b, txd, exp);
                end
                nrx++;
            end
            for (int i = 0; i < 3; i++) begin
                if (gnt[i]) begin
                    ptr[i]++;
                    if (ptr[i] == 8) req[i] = 1'b0;
                    else req_data[i*8 +: 8] = 8'((i + 1) * 16 + ptr[i]);
                end
            end
        end
        n_vec++; if (nrx !== 24) begin n_err++; $display("FAIL e2e_count got %0d want 24", nrx); end
        n_vec++; if (frame_cnt !== 16'd24) begin n_err++; $display("FAIL e2e_frame_cnt got %0d want 24", frame_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        req      = 4'h0;
        req_data = 32'h0;
        test_reset();
        test_single();
        test_round_robin();
        test_enable();
        test_mid_reset();
        test_end_to_end();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
